// File: rtl/cuckoo_pkg.sv
// Shared types, default widths and the chunk-folding hash functions for the cuckoo insert controller.
package cuckoo_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, T1, T2, DONE} state_t;

    localparam int DEF_KEY_W     = 32;
    localparam int DEF_IDX_W     = 4;
    localparam int DEF_MAX_KICKS = 8;
    localparam int DEF_KICK_W    = 4;

    // Widest key / index the hash helpers accept; narrower keys are zero-extended by callers.
    localparam int HASH_KEY_W = 64;
    localparam int HASH_IDX_W = 16;

    // XOR together every chunk whose index has the given parity (0 = even chunks, 1 = odd chunks).
    function automatic logic [HASH_IDX_W-1:0] fold_chunks(input logic [HASH_KEY_W-1:0] key,
                                                          input int idx_w, input int parity);
        logic [HASH_IDX_W-1:0] acc;
        logic [HASH_KEY_W-1:0] mask;
        acc  = '0;
        mask = (HASH_KEY_W'(1) << idx_w) - HASH_KEY_W'(1);
        for (int i = 0; i < HASH_KEY_W; i++) begin
            if ((i % 2) == parity) begin
                acc = acc ^ HASH_IDX_W'((key >> (i * idx_w)) & mask);
            end
        end
        return acc;
    endfunction

    function automatic logic [HASH_IDX_W-1:0] h1(input logic [HASH_KEY_W-1:0] key, input int idx_w);
        return fold_chunks(key, idx_w, 0);
    endfunction

    function automatic logic [HASH_IDX_W-1:0] h2(input logic [HASH_KEY_W-1:0] key, input int idx_w);
        return fold_chunks(key, idx_w, 1);
    endfunction

endpackage

// File: rtl/cuckoo_table.sv
// One cuckoo table: key storage, per-slot filled bits, a single write/swap port
// and two combinational read ports (one for the sequencer, one for lookups).
module cuckoo_table
    import cuckoo_pkg::*;
#(
    parameter int KEY_W = DEF_KEY_W,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [KEY_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [KEY_W-1:0] rdata,
    output logic             rfilled,
    input  logic [IDX_W-1:0] laddr,
    output logic [KEY_W-1:0] ldata,
    output logic             lfilled
);
    localparam int DEPTH = 2 ** IDX_W;

    logic [KEY_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0] filled;

    // Data carries no reset; validity lives entirely in the filled bits.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filled <= '0;
        end else if (clr) begin
            filled <= '0;
        end else if (we) begin
            filled[waddr] <= 1'b1;
        end
    end

    assign rdata   = mem[raddr];
    assign rfilled = filled[raddr];
    assign ldata   = mem[laddr];
    assign lfilled = filled[laddr];

endmodule

// File: rtl/cuckoo_insert_ctrl.sv
// Multi-cycle insert sequencer for a two-table cuckoo hash: probe for duplicates,
// then alternate place/evict between the tables until a key lands or the kick limit hits.
module cuckoo_insert_ctrl
    import cuckoo_pkg::*;
#(
    parameter int KEY_W     = DEF_KEY_W,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int MAX_KICKS = DEF_MAX_KICKS,
    parameter int KICK_W    = DEF_KICK_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [KEY_W-1:0]   in_key,
    input  logic               clr,
    output logic               done_valid,
    output logic               done_ok,
    output logic               done_dup,
    output logic [KICK_W-1:0]  done_kicks,
    output logic [KEY_W-1:0]   done_key,
    output logic [IDX_W+1:0]   occupancy,
    input  logic [KEY_W-1:0]   lk_key,
    output logic               lk_hit
);
    state_t            state;
    logic [KEY_W-1:0]  cur_key;
    logic [KEY_W-1:0]  orig_key;
    logic [KICK_W-1:0] kicks;
    logic [KICK_W-1:0] kicks_inc;

    logic [IDX_W-1:0]  cur_h1, cur_h2, lk_h1, lk_h2;
    logic [KEY_W-1:0]  rdata1, rdata2, ldata1, ldata2;
    logic              rfilled1, rfilled2, lfilled1, lfilled2;
    logic              tbl_clr, cur_hit, slot_filled;
    logic [KEY_W-1:0]  slot_data;

    assign cur_h1 = IDX_W'(h1(HASH_KEY_W'(cur_key), IDX_W));
    assign cur_h2 = IDX_W'(h2(HASH_KEY_W'(cur_key), IDX_W));
    assign lk_h1  = IDX_W'(h1(HASH_KEY_W'(lk_key), IDX_W));
    assign lk_h2  = IDX_W'(h2(HASH_KEY_W'(lk_key), IDX_W));

    assign in_ready = (state == IDLE) && !clr;
    assign tbl_clr  = (state == IDLE) && clr;

    cuckoo_table #(.KEY_W(KEY_W), .IDX_W(IDX_W)) u_t1 (
        .clk(clk), .rst_n(rst_n), .clr(tbl_clr),
        .we(state == T1), .waddr(cur_h1), .wdata(cur_key),
        .raddr(cur_h1), .rdata(rdata1), .rfilled(rfilled1),
        .laddr(lk_h1), .ldata(ldata1), .lfilled(lfilled1)
    );

    cuckoo_table #(.KEY_W(KEY_W), .IDX_W(IDX_W)) u_t2 (
        .clk(clk), .rst_n(rst_n), .clr(tbl_clr),
        .we(state == T2), .waddr(cur_h2), .wdata(cur_key),
        .raddr(cur_h2), .rdata(rdata2), .rfilled(rfilled2),
        .laddr(lk_h2), .ldata(ldata2), .lfilled(lfilled2)
    );

    assign cur_hit     = (rfilled1 && rdata1 == cur_key) || (rfilled2 && rdata2 == cur_key);
    assign lk_hit      = (lfilled1 && ldata1 == lk_key) || (lfilled2 && ldata2 == lk_key);
    assign slot_filled = (state == T1) ? rfilled1 : rfilled2;
    assign slot_data   = (state == T1) ? rdata1 : rdata2;
    assign kicks_inc   = kicks + KICK_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_key    <= '0;
            orig_key   <= '0;
            kicks      <= '0;
            occupancy  <= '0;
            done_valid <= 1'b0;
            done_ok    <= 1'b0;
            done_dup   <= 1'b0;
            done_kicks <= '0;
            done_key   <= '0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        occupancy <= '0;
                    end else if (in_valid) begin
                        cur_key  <= in_key;
                        orig_key <= in_key;
                        kicks    <= '0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (cur_hit) begin
                        done_valid <= 1'b1;
                        done_ok    <= 1'b1;
                        done_dup   <= 1'b1;
                        done_kicks <= kicks;
                        done_key   <= orig_key;
                        state      <= DONE;
                    end else begin
                        state <= T1;
                    end
                end
                T1, T2: begin
                    // The table write of cur_key happens in both branches; only the bookkeeping differs.
                    if (!slot_filled) begin
                        occupancy  <= occupancy + (IDX_W+2)'(1);
                        done_valid <= 1'b1;
                        done_ok    <= 1'b1;
                        done_dup   <= 1'b0;
                        done_kicks <= kicks;
                        done_key   <= orig_key;
                        state      <= DONE;
                    end else begin
                        cur_key <= slot_data;
                        kicks   <= kicks_inc;
                        if (kicks_inc == KICK_W'(MAX_KICKS)) begin
                            done_valid <= 1'b1;
                            done_ok    <= 1'b0;
                            done_dup   <= 1'b0;
                            done_kicks <= kicks_inc;
                            done_key   <= slot_data;
                            state      <= DONE;
                        end else begin
                            state <= (state == T1) ? T2 : T1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
